// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
// Round-robin arbiter/sequencer in front of a bank of external SR flip-flops.
// Requests (set/reset/toggle/no-op) are turned into single-cycle one-hot S or R
// pulses, the bank output Q is read back one cycle later to confirm the result,
// and a one-hot Done (plus Err on mismatch or bad index) closes each operation.
// After reset the whole bank is cleared once before any request is accepted.
module sr_flag_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned NUM_FLAGS = 8,
    parameter int unsigned IDX_W     = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [2*NUM_REQ-1:0]     i_op,
    input  logic [IDX_W*NUM_REQ-1:0] i_idx,
    input  logic [NUM_FLAGS-1:0]     i_q,
    output logic [NUM_FLAGS-1:0]     o_s,
    output logic [NUM_FLAGS-1:0]     o_r,
    output logic [NUM_REQ-1:0]       o_gnt,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_err,
    output logic                     o_busy,
    output logic                     o_init_done
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_INIT_DRV,
        ST_INIT_CHK,
        ST_IDLE,
        ST_DRIVE,
        ST_CHECK
    } state_t;

    // State and registered outputs
    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [NUM_FLAGS-1:0] r_s;
    logic [NUM_FLAGS-1:0] r_r;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_init_done;

    // Operation latched at grant time, consumed in CHECK
    logic [1:0]           r_op;
    logic [NUM_FLAGS-1:0] r_idx_oh;
    logic                 r_in_range;
    logic                 r_exp;
    logic [NUM_REQ-1:0]   r_win_oh;
    logic [PTR_W-1:0]     r_win_num;

    // Next-state values
    state_t               w_nxt_state;
    logic [PTR_W-1:0]     w_nxt_ptr;
    logic [NUM_FLAGS-1:0] w_nxt_s;
    logic [NUM_FLAGS-1:0] w_nxt_r;
    logic [NUM_REQ-1:0]   w_nxt_gnt;
    logic [NUM_REQ-1:0]   w_nxt_done;
    logic                 w_nxt_err;
    logic                 w_nxt_busy;
    logic                 w_nxt_init_done;
    logic [1:0]           w_nxt_op;
    logic [NUM_FLAGS-1:0] w_nxt_idx_oh;
    logic                 w_nxt_in_range;
    logic                 w_nxt_exp;
    logic [NUM_REQ-1:0]   w_nxt_win_oh;
    logic [PTR_W-1:0]     w_nxt_win_num;

    // Arbitration and operand selection
    logic                 w_found;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [PTR_W-1:0]     w_win_num;
    logic [1:0]           w_sel_op;
    logic [IDX_W-1:0]     w_sel_idx;
    logic [NUM_FLAGS-1:0] w_sel_oh;
    logic                 w_sel_in_range;
    logic                 w_sel_q;
    logic                 w_chk_q;

    // Round-robin search: first requesting index at or above the pointer, wrapping
    always_comb begin
        int unsigned v_pos;
        w_found   = 1'b0;
        w_win_oh  = '0;
        w_win_num = '0;
        v_pos     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_pos = 32'(r_ptr) + k;
            if (v_pos >= NUM_REQ) begin
                v_pos = v_pos - NUM_REQ;
            end
            for (int unsigned n = 0; n < NUM_REQ; n++) begin
                if (!w_found && (v_pos == n) && i_req[n]) begin
                    w_found     = 1'b1;
                    w_win_oh[n] = 1'b1;
                    w_win_num   = PTR_W'(n);
                end
            end
        end
    end

    // Winner's op/index mux and flag decode; an index beyond the bank decodes to all-zero
    always_comb begin
        w_sel_op  = OP_NOP;
        w_sel_idx = '0;
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            if (w_win_oh[n]) begin
                w_sel_op  = i_op[2*n +: 2];
                w_sel_idx = i_idx[IDX_W*n +: IDX_W];
            end
        end
        w_sel_oh = '0;
        for (int unsigned f = 0; f < NUM_FLAGS; f++) begin
            w_sel_oh[f] = (w_sel_idx == IDX_W'(f));
        end
        w_sel_in_range = |w_sel_oh;
        w_sel_q        = |(i_q & w_sel_oh);
        w_chk_q        = |(i_q & r_idx_oh);
    end

    // Next-state and output decode; pulses default low so every S/R/Gnt/Done/Err lasts one cycle
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_ptr       = r_ptr;
        w_nxt_s         = '0;
        w_nxt_r         = '0;
        w_nxt_gnt       = '0;
        w_nxt_done      = '0;
        w_nxt_err       = 1'b0;
        w_nxt_init_done = r_init_done;
        w_nxt_op        = r_op;
        w_nxt_idx_oh    = r_idx_oh;
        w_nxt_in_range  = r_in_range;
        w_nxt_exp       = r_exp;
        w_nxt_win_oh    = r_win_oh;
        w_nxt_win_num   = r_win_num;

        case (r_state)
            ST_INIT: begin
                w_nxt_r     = '1;
                w_nxt_state = ST_INIT_DRV;
            end
            ST_INIT_DRV: begin
                w_nxt_state = ST_INIT_CHK;
            end
            ST_INIT_CHK: begin
                w_nxt_init_done = 1'b1;
                w_nxt_err       = |i_q;
                w_nxt_state     = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_found) begin
                    w_nxt_op       = w_sel_op;
                    w_nxt_idx_oh   = w_sel_oh;
                    w_nxt_in_range = w_sel_in_range;
                    w_nxt_win_oh   = w_win_oh;
                    w_nxt_win_num  = w_win_num;
                    w_nxt_gnt      = w_win_oh;
                    // w_sel_oh is zero for an out-of-range index, which suppresses the pulse
                    case (w_sel_op)
                        OP_SET: begin
                            w_nxt_s   = w_sel_oh;
                            w_nxt_exp = 1'b1;
                        end
                        OP_RST: begin
                            w_nxt_r   = w_sel_oh;
                            w_nxt_exp = 1'b0;
                        end
                        OP_TGL: begin
                            if (w_sel_q) begin
                                w_nxt_r = w_sel_oh;
                            end else begin
                                w_nxt_s = w_sel_oh;
                            end
                            w_nxt_exp = !w_sel_q;
                        end
                        default: begin
                            w_nxt_exp = 1'b0;
                        end
                    endcase
                    w_nxt_state = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_nxt_state = ST_CHECK;
            end
            ST_CHECK: begin
                w_nxt_done = r_win_oh;
                w_nxt_err  = !r_in_range || ((r_op != OP_NOP) && (w_chk_q != r_exp));
                if (r_win_num == PTR_W'(NUM_REQ - 1)) begin
                    w_nxt_ptr = '0;
                end else begin
                    w_nxt_ptr = r_win_num + PTR_W'(1);
                end
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_INIT;
            end
        endcase

        w_nxt_busy = (w_nxt_state != ST_IDLE);
    end

    // State register with synchronous reset; reset abandons any operation in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_INIT;
            r_ptr       <= '0;
            r_s         <= '0;
            r_r         <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
            r_op        <= OP_NOP;
            r_idx_oh    <= '0;
            r_in_range  <= 1'b0;
            r_exp       <= 1'b0;
            r_win_oh    <= '0;
            r_win_num   <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_ptr       <= w_nxt_ptr;
            r_s         <= w_nxt_s;
            r_r         <= w_nxt_r;
            r_gnt       <= w_nxt_gnt;
            r_done      <= w_nxt_done;
            r_err       <= w_nxt_err;
            r_busy      <= w_nxt_busy;
            r_init_done <= w_nxt_init_done;
            r_op        <= w_nxt_op;
            r_idx_oh    <= w_nxt_idx_oh;
            r_in_range  <= w_nxt_in_range;
            r_exp       <= w_nxt_exp;
            r_win_oh    <= w_nxt_win_oh;
            r_win_num   <= w_nxt_win_num;
        end
    end

    assign o_s         = r_s;
    assign o_r         = r_r;
    assign o_gnt       = r_gnt;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_busy      = r_busy;
    assign o_init_done = r_init_done;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Testbench for sr_flag_arbiter: behavioural SR bank on Q, directed scenarios
// plus randomized request rounds checked against a transaction-level model.
module tb_sr_flag_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned NF = 8;
    localparam int unsigned IW = 4;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [2*NR-1:0] op = '0;
    logic [IW*NR-1:0] idx = '0;
    logic [NF-1:0]  q;
    logic [NF-1:0]  s, r;
    logic [NR-1:0]  gnt, done;
    logic           err, busy, init_done;

    // External SR bank; hold masks let the bench pin individual Q bits
    logic [NF-1:0] bank  = 8'hA5;
    logic [NF-1:0] hold0 = '0;
    logic [NF-1:0] hold1 = '0;
    always @(posedge clk) bank <= (bank | s) & ~r;
    assign q = (bank & ~hold0) | hold1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int unsigned   m_ptr   = 0;
    logic [NF-1:0] m_flags = '0;

    sr_flag_arbiter #(
        .NUM_REQ  (NR),
        .NUM_FLAGS(NF),
        .IDX_W    (IW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_op       (op),
        .i_idx      (idx),
        .i_q        (q),
        .o_s        (s),
        .o_r        (r),
        .o_gnt      (gnt),
        .o_done     (done),
        .o_err      (err),
        .o_busy     (busy),
        .o_init_done(init_done)
    );

    // Continuous invariants on the S/R/Gnt/Done outputs
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_tests++;
            if ((s & r) !== '0) begin
                n_fail++;
                $display("FAIL inv_s_and_r s=%h r=%h required (s&r)=0", s, r);
            end
            n_tests++;
            if (!(r === '1) && ($countones(s | r) > 1)) begin
                n_fail++;
                $display("FAIL inv_sr_onehot s=%h r=%h required at most one bit", s, r);
            end
            n_tests++;
            if ($countones(gnt) > 1 || $countones(done) > 1) begin
                n_fail++;
                $display("FAIL inv_gnt_done_onehot gnt=%b done=%b required at most one-hot", gnt, done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned k, input logic [1:0] o, input logic [IW-1:0] ix);
        req[k] = 1'b1;
        op[2*k +: 2] = o;
        idx[IW*k +: IW] = ix;
    endtask

    // Waits (bounded) for a grant and captures the outputs visible with it
    task automatic wait_grant(output logic [NR-1:0] g, output logic [NF-1:0] gs,
                              output logic [NF-1:0] gr, output int unsigned cyc);
        g = '0; gs = '0; gr = '0; cyc = 0;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (gnt !== '0) begin
                g = gnt; gs = s; gr = r;
                return;
            end
        end
    endtask

    // Captures Done in CHECK (must be quiet) and Done/Err one cycle later
    task automatic wait_done(output logic [NR-1:0] mid, output logic [NR-1:0] d, output logic e);
        tick();
        mid = done;
        tick();
        d = done;
        e = err;
    endtask

    function automatic int unsigned rr_pick(input int unsigned ptr, input logic [NR-1:0] pend);
        for (int unsigned k = 0; k < NR; k++) begin
            if (pend[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return NR;
    endfunction

    // Spec rules for one operation: pulse, error and resulting flag contents
    function automatic void predict(input logic [1:0] o, input int unsigned ix, input logic [NF-1:0] fl,
                                    output logic [NF-1:0] es, output logic [NF-1:0] er,
                                    output logic eerr, output logic [NF-1:0] nfl);
        es = '0; er = '0; nfl = fl; eerr = (ix >= NF);
        if (ix < NF) begin
            case (o)
                OP_SET: begin es[ix] = 1'b1; nfl[ix] = 1'b1; end
                OP_RST: begin er[ix] = 1'b1; nfl[ix] = 1'b0; end
                OP_TGL: begin
                    if (fl[ix]) begin er[ix] = 1'b1; nfl[ix] = 1'b0; end
                    else begin es[ix] = 1'b1; nfl[ix] = 1'b1; end
                end
                default: ;
            endcase
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = '0; op = '0; idx = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (r !== 8'hFF || s !== '0 || init_done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rpulse r=%h s=%h init_done=%b busy=%b required r=ff s=00 init_done=0 busy=1", r, s, init_done, busy);
        end
        tick();
        n_tests++;
        if (r !== '0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdrop r=%h init_done=%b required r=00 init_done=0", r, init_done);
        end
        tick();
        n_tests++;
        if (init_done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || gnt !== '0 || done !== '0) begin
            n_fail++;
            $display("FAIL reset_initdone init_done=%b err=%b busy=%b required 1 0 0", init_done, err, busy);
        end
        tick();
        m_ptr = 0;
        m_flags = '0;
        n_tests++;
        if (err !== 1'b0 || init_done !== 1'b1 || q !== m_flags) begin
            n_fail++;
            $display("FAIL reset_settle err=%b init_done=%b q=%h required 0 1 00", err, init_done, q);
        end
    endtask

    task automatic test_set();
        logic [NR-1:0] g, md, d; logic [NF-1:0] gs, gr; logic e; int unsigned c;
        set_req(0, OP_SET, 4'd3);
        wait_grant(g, gs, gr, c);
        req[0] = 1'b0;
        n_tests++;
        if (g !== 4'b0001 || gs !== 8'h08 || gr !== '0 || c != 1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL set_grant gnt=%b s=%h r=%h cyc=%0d busy=%b required 0001 08 00 1 1", g, gs, gr, c, busy);
        end
        wait_done(md, d, e);
        m_flags[3] = 1'b1;
        m_ptr = 1;
        n_tests++;
        if (md !== '0 || d !== 4'b0001 || e !== 1'b0 || q !== m_flags) begin
            n_fail++;
            $display("FAIL set_done mid=%b done=%b err=%b q=%h required 0000 0001 0 %h", md, d, e, q, m_flags);
        end
    endtask

    task automatic test_toggle();
        logic [NR-1:0] g, md, d; logic [NF-1:0] gs, gr; logic e; int unsigned c;
        set_req(1, OP_TGL, 4'd3);
        wait_grant(g, gs, gr, c);
        req[1] = 1'b0;
        n_tests++;
        if (g !== 4'b0010 || gs !== '0 || gr !== 8'h08 || c != 1) begin
            n_fail++;
            $display("FAIL toggle_grant gnt=%b s=%h r=%h cyc=%0d required 0010 00 08 1", g, gs, gr, c);
        end
        wait_done(md, d, e);
        m_flags[3] = 1'b0;
        m_ptr = 2;
        n_tests++;
        if (d !== 4'b0010 || e !== 1'b0 || q !== m_flags) begin
            n_fail++;
            $display("FAIL toggle_done done=%b err=%b q=%h required 0010 0 %h", d, e, q, m_flags);
        end
    endtask

    task automatic test_errors();
        logic [NR-1:0] g, md, d; logic [NF-1:0] gs, gr; logic e; int unsigned c;
        hold0[5] = 1'b1;
        set_req(2, OP_SET, 4'd5);
        wait_grant(g, gs, gr, c);
        req[2] = 1'b0;
        n_tests++;
        if (g !== 4'b0100 || gs !== 8'h20 || gr !== '0) begin
            n_fail++;
            $display("FAIL stuck_grant gnt=%b s=%h r=%h required 0100 20 00", g, gs, gr);
        end
        wait_done(md, d, e);
        n_tests++;
        if (d !== 4'b0100 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_err done=%b err=%b required 0100 1", d, e);
        end
        hold0 = '0;
        m_flags[5] = 1'b1;
        set_req(2, OP_SET, 4'd9);
        wait_grant(g, gs, gr, c);
        req[2] = 1'b0;
        n_tests++;
        if (g !== 4'b0100 || gs !== '0 || gr !== '0) begin
            n_fail++;
            $display("FAIL range_grant gnt=%b s=%h r=%h required 0100 00 00", g, gs, gr);
        end
        wait_done(md, d, e);
        n_tests++;
        if (d !== 4'b0100 || e !== 1'b1 || q !== m_flags) begin
            n_fail++;
            $display("FAIL range_err done=%b err=%b q=%h required 0100 1 %h", d, e, q, m_flags);
        end
        set_req(3, OP_NOP, 4'd0);
        wait_grant(g, gs, gr, c);
        req[3] = 1'b0;
        wait_done(md, d, e);
        m_ptr = 0;
        n_tests++;
        if (g !== 4'b1000 || gs !== '0 || gr !== '0 || d !== 4'b1000 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL nop gnt=%b s=%h r=%h done=%b err=%b required 1000 00 00 1000 0", g, gs, gr, d, e);
        end
    endtask

    task automatic test_all_four();
        logic [NR-1:0] g, md, d, eg; logic [NF-1:0] gs, gr, es, er, nfl; logic e, ee; int unsigned c;
        logic [1:0] ops [NR];
        int unsigned ixs [NR];
        ops[0] = OP_SET; ixs[0] = 1;
        ops[1] = OP_RST; ixs[1] = 1;
        ops[2] = OP_TGL; ixs[2] = 6;
        ops[3] = OP_SET; ixs[3] = 7;
        for (int unsigned k = 0; k < NR; k++) set_req(k, ops[k], IW'(ixs[k]));
        for (int unsigned k = 0; k < NR; k++) begin
            wait_grant(g, gs, gr, c);
            req = req & ~g;
            predict(ops[k], ixs[k], m_flags, es, er, ee, nfl);
            eg = '0; eg[k] = 1'b1;
            n_tests++;
            if (g !== eg || gs !== es || gr !== er || c != 1) begin
                n_fail++;
                $display("FAIL all4_grant%0d gnt=%b s=%h r=%h cyc=%0d required %b %h %h 1", k, g, gs, gr, c, eg, es, er);
            end
            wait_done(md, d, e);
            m_flags = nfl;
            n_tests++;
            if (d !== eg || e !== ee || q !== m_flags) begin
                n_fail++;
                $display("FAIL all4_done%0d done=%b err=%b q=%h required %b %b %h", k, d, e, q, eg, ee, m_flags);
            end
        end
        // Pointer must be back at 0: requester 0 beats requester 3
        set_req(3, OP_NOP, 4'd0);
        set_req(0, OP_NOP, 4'd0);
        wait_grant(g, gs, gr, c);
        req = req & ~g;
        wait_done(md, d, e);
        n_tests++;
        if (g !== 4'b0001 || d !== 4'b0001) begin
            n_fail++;
            $display("FAIL all4_ptr gnt=%b done=%b required 0001 0001", g, d);
        end
        wait_grant(g, gs, gr, c);
        req = req & ~g;
        wait_done(md, d, e);
        m_ptr = 0;
        n_tests++;
        if (g !== 4'b1000 || c != 1) begin
            n_fail++;
            $display("FAIL all4_ptr_next gnt=%b cyc=%0d required 1000 1", g, c);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [NR-1:0] g; logic [NF-1:0] gs, gr; int unsigned c;
        hold1[2] = 1'b1;
        set_req(1, OP_SET, 4'd4);
        wait_grant(g, gs, gr, c);
        n_tests++;
        if (g !== 4'b0010 || gs !== 8'h10) begin
            n_fail++;
            $display("FAIL rstmid_grant gnt=%b s=%h required 0010 10", g, gs);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (s !== '0 || r !== '0 || gnt !== '0 || done !== '0 || err !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear s=%h r=%h gnt=%b done=%b err=%b init_done=%b required all 0", s, r, gnt, done, err, init_done);
        end
        req = '0;
        rst = 1'b0;
        tick();
        n_tests++;
        if (r !== 8'hFF || done !== '0) begin
            n_fail++;
            $display("FAIL rstmid_rpulse r=%h done=%b required ff 0000", r, done);
        end
        tick();
        n_tests++;
        if (r !== '0 || init_done !== 1'b0 || done !== '0) begin
            n_fail++;
            $display("FAIL rstmid_rdrop r=%h init_done=%b required 00 0", r, init_done);
        end
        tick();
        n_tests++;
        if (init_done !== 1'b1 || err !== 1'b1 || done !== '0) begin
            n_fail++;
            $display("FAIL rstmid_initerr init_done=%b err=%b done=%b required 1 1 0000", init_done, err, done);
        end
        tick();
        n_tests++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_errpulse err=%b busy=%b required 0 0", err, busy);
        end
        hold1 = '0;
        m_flags = '0;
        m_ptr = 0;
    endtask

    task automatic test_random();
        logic [NR-1:0] g, md, d, eg, pend; logic [NF-1:0] gs, gr, es, er, nfl; logic e, ee; int unsigned c, w;
        logic [1:0] ops [NR];
        int unsigned ixs [NR];
        for (int round = 0; round < 40; round++) begin
            pend = NR'($urandom_range(1, (1 << NR) - 1));
            for (int unsigned k = 0; k < NR; k++) begin
                ops[k] = 2'($urandom_range(0, 3));
                ixs[k] = $urandom_range(0, 9);
                if (pend[k]) set_req(k, ops[k], IW'(ixs[k]));
            end
            while (pend != '0) begin
                w = rr_pick(m_ptr, pend);
                eg = '0; eg[w] = 1'b1;
                predict(ops[w], ixs[w], m_flags, es, er, ee, nfl);
                wait_grant(g, gs, gr, c);
                req = req & ~g;
                pend[w] = 1'b0;
                n_tests++;
                if (g !== eg || gs !== es || gr !== er || c != 1) begin
                    n_fail++;
                    $display("FAIL rand_grant r%0d gnt=%b s=%h r=%h cyc=%0d required %b %h %h 1", round, g, gs, gr, c, eg, es, er);
                end
                if (g === '0) begin
                    req = '0;
                    pend = '0;
                end
                wait_done(md, d, e);
                m_flags = nfl;
                m_ptr = (w + 1) % NR;
                n_tests++;
                if (md !== '0 || d !== eg || e !== ee || q !== m_flags) begin
                    n_fail++;
                    $display("FAIL rand_done r%0d mid=%b done=%b err=%b q=%h required 0000 %b %b %h", round, md, d, e, q, eg, ee, m_flags);
                end
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_set();
        test_toggle();
        test_errors();
        test_all_four();
        test_reset_mid_op();
        test_random();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout time=%0t required completion before 500000", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
Round-robin arbiter and sequencer that shares a bank of NUM_FLAGS external SR flip-flops between NUM_REQ requesters.
- Converts set / reset / toggle / no-op requests into single-cycle, one-hot S or R pulses.
- Never drives S and R high together for the same flag, so the illegal S=R=1 condition cannot occur.
- Reads back Q to confirm each operation.
- Sits between control logic and the flag bank; the bank's S/R inputs are driven only by this block.

Parameters:
NUM_REQ, 4, number of requesters
NUM_FLAGS, 8, number of SR flip-flops in the bank
IDX_W, 3, flag index width; NUM_FLAGS <= 2**IDX_W

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous, active-high reset
Req  input  NUM_REQ  per-requester request
Op  input  2*NUM_REQ  per-requester op, 2 bits each: 00 no-op, 01 set, 10 reset, 11 toggle
Idx  input  IDX_W*NUM_REQ  per-requester flag index
Q  input  NUM_FLAGS  flag bank outputs
S  output  NUM_FLAGS  set pulses to the bank (registered)
R  output  NUM_FLAGS  reset pulses to the bank (registered)
Gnt  output  NUM_REQ  one-hot grant pulse
Done  output  NUM_REQ  one-hot completion pulse
Err  output  1  error pulse, aligned with Done or with Init_Done
Busy  output  1  high whenever state is not IDLE
Init_Done  output  1  level; high once the bank has been cleared after reset

Behaviour:
- All outputs are registered.
- Rst (sampled on the Clk edge):
  - S, R, Gnt, Done, Err, Init_Done go to 0.
  - Round-robin pointer goes to 0.
  - State goes to INIT.
  - Rst mid-operation abandons the operation; no Done or Err is issued.
- INIT:
  - At the edge: R <= all ones, state <= INIT_DRV.
- INIT_DRV:
  - R is all ones for exactly 1 cycle.
  - At the edge: R <= 0, state <= INIT_CHK.
- INIT_CHK:
  - At the edge: Init_Done <= 1; Err <= 1 for 1 cycle if Q != 0; state <= IDLE.
  - Req is ignored in every state before IDLE.
- IDLE, cycle t, when any Req is high:
  - Winner w = first requester with Req high, searching from the pointer upward with wrap-around.
  - At the end of cycle t, latch Op[w] and Idx[w], then:
    - set: S[Idx] <= 1
    - reset: R[Idx] <= 1
    - toggle: R[Idx] <= 1 if Q[Idx] == 1 at that edge, else S[Idx] <= 1
    - no-op, or Idx >= NUM_FLAGS: no S/R pulse
  - Expected value E is latched with the operation: set gives 1, reset gives 0, toggle gives the inverse of Q[Idx].
  - Gnt[w] <= 1; state <= DRIVE.
- DRIVE, cycle t+1:
  - Gnt[w] and the S/R pulse are visible; the bank captures at the end of t+1.
  - At the edge: S, R, Gnt <= 0; state <= CHECK.
- CHECK, cycle t+2:
  - At the edge: Done[w] <= 1; pointer <= (w+1) mod NUM_REQ; state <= IDLE.
  - Err <= 1 if Idx is out of range, or if the op is not a no-op and Q[Idx] != E.
- Cycle t+3: Done[w] and Err are visible.
- Throughput and latency:
  - One operation per 3 cycles.
  - Latency from Req seen to Done visible: 3 cycles.
- Requester handshake:
  - Hold Req, Op and Idx stable until Gnt.
  - Drop Req by cycle t+2; if Req is still high in t+3, it is treated as a new request.
- Invariants:
  - (S & R) == 0 at all times.
  - popcount(S|R) <= 1, except in INIT_DRV.
  - Gnt and Done are each at most one-hot.
- A requester dropping Req before it is granted is not served.
- Same flag targeted by several requesters: the operations are serialized in round-robin order, and each is checked independently.

Test Plan:
- Reset release, Q follows R correctly → R=0xFF for exactly 1 cycle, Init_Done rises 2 cycles after the R pulse, Err=0, Busy=0 in IDLE.
- Req0 set Idx=3 → Gnt=0001 and S=0x08 in the same cycle, Q[3]=1, Done=0001 3 cycles after Req was seen, Err=0.
- Req1 toggle Idx=3 with Q[3]=1 → R=0x08 and S=0x00; Q[3]=0; Done=0010, Err=0.
- Req0..3 all raised together, pointer=0 and held until granted → grants in order 0,1,2,3, spaced 3 cycles apart; pointer=0 afterwards.
- Req2 set Idx=5 while the bench holds Q[5]=0 → Done=0100 with Err=1; then Idx=9 with NUM_FLAGS=8 → no S/R pulse, Done plus Err=1.
- Rst asserted during DRIVE → S=R=0 on the next cycle, no Done; INIT sequence repeats and Init_Done goes 0 then 1.
